fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of decode.
- Owns the program counter and issues in-order word requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a small FIFO and presents one instruction per cycle to decode, together with its PC.
- Handles stall from downstream and PC redirects (branch/jump) from execute, including discard of in-flight responses.

---
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order word requests to imem,
// buffers returned words and presents one instruction per cycle to decode.
module fetch_stage #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   BUF_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [WORD_SIZE-1:0] imem_resp_data,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 stall,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] instruction_pc,
  output logic                 instruction_valid
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]          DEPTH_C = (CW+1)'(BUF_DEPTH);
  localparam logic [WORD_SIZE-1:0] NOP     = WORD_SIZE'(32'h0000_0013);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    logic [WORD_SIZE-1:0] pc;
  } entry_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] pc;
  logic [CW-1:0]        drop_count, drop_nxt;

  // instruction buffer (word + pc) and per-request pc queue; the pc queue
  // holds exactly the live (non-dropped) outstanding requests
  entry_t               ibuf [BUF_DEPTH];
  logic [PW-1:0]        ib_head, ib_tail;
  logic [CW-1:0]        ib_cnt;
  logic [WORD_SIZE-1:0] pcq  [BUF_DEPTH];
  logic [PW-1:0]        pq_head, pq_tail;
  logic [CW-1:0]        outstanding;

  logic        accept, pop, resp_live, resp_drop;
  logic [CW:0] used;
  entry_t      head;

  assign head              = ibuf[ib_head];
  assign instruction_valid = (ib_cnt != '0);
  assign instruction       = instruction_valid ? head.data : NOP;
  assign instruction_pc    = instruction_valid ? head.pc   : '0;
  assign pop               = instruction_valid && !stall;

  // a slot freed by this cycle's pop is reusable, so back-to-back fetch
  // sustains one word per cycle with only two credits
  assign used           = {1'b0, outstanding} + {1'b0, ib_cnt} - (CW+1)'(pop);
  assign imem_req_valid = (state == RUN) && (used < DEPTH_C);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // responses with nothing live outstanding (e.g. issued before reset) are ignored
  assign resp_drop = imem_resp_valid && (drop_count != '0);
  assign resp_live = imem_resp_valid && (drop_count == '0) && (outstanding != '0);

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_count;
    if (resp_drop) drop_nxt = drop_count - CW'(1);
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      DRAIN:   if (drop_nxt == '0) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
    if (redirect_valid) begin
      // everything still in flight after this edge must be discarded
      drop_nxt  = drop_count + outstanding + CW'(accept) - CW'(resp_drop) - CW'(resp_live);
      state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      drop_count  <= '0;
      ib_head     <= '0;
      ib_tail     <= '0;
      ib_cnt      <= '0;
      pq_head     <= '0;
      pq_tail     <= '0;
      outstanding <= '0;
    end else begin
      state      <= state_nxt;
      drop_count <= drop_nxt;
      if (redirect_valid) begin
        pc          <= redirect_pc & ~WORD_SIZE'(3);
        ib_head     <= '0;
        ib_tail     <= '0;
        ib_cnt      <= '0;
        pq_head     <= '0;
        pq_tail     <= '0;
        outstanding <= '0;
      end else begin
        if (accept) begin
          pc      <= pc + WORD_SIZE'(4);
          pq_tail <= pq_tail + PW'(1);
        end
        if (resp_live) begin
          ib_tail <= ib_tail + PW'(1);
          pq_head <= pq_head + PW'(1);
        end
        if (pop) ib_head <= ib_head + PW'(1);
        ib_cnt      <= ib_cnt + CW'(resp_live) - CW'(pop);
        outstanding <= outstanding + CW'(accept) - CW'(resp_live);
      end
    end
  end

  // storage arrays need no reset; validity is tracked by the counters above
  always_ff @(posedge clock) begin
    if (accept)    pcq[pq_tail]  <= pc;
    if (resp_live) ibuf[ib_tail] <= '{data: imem_resp_data, pc: pcq[pq_head]};
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table for streaming/stall/backpressure,
// plus hand sequences for redirect, drop, same-cycle collisions and pc wrap.
module tb_fetch_stage;
  localparam logic [31:0] KEY = 32'h5A5A_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction, instruction_pc;
  logic        instruction_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];

  typedef struct {
    logic        stall;
    logic        ready;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[21];

  fetch_stage #(.WORD_SIZE(32), .RESET_PC(32'h100), .BUF_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .instruction(instruction), .instruction_pc(instruction_pc),
    .instruction_valid(instruction_valid)
  );

  always #5 clock = ~clock;

  // in-order memory with fixed latency; accept sampled just before the edge
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clock); #1;
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_q[0].addr ^ KEY;
        void'(mem_q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
      @(negedge clock); #3;
      if (reset) mem_q.delete();
      else if (imem_req_valid && imem_req_ready)
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
    redirect_pc = '0;
    @(posedge clock); @(posedge clock); @(negedge clock);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_ivalid",    32'(instruction_valid), 32'd0);
    chk("rst_instr",     instruction, NOP);
    chk("rst_ipc",       instruction_pc, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic wait_iv(input string name);
    int n = 0;
    while (!instruction_valid && n < 30) begin
      @(posedge clock); #1; @(negedge clock);
      n++;
    end
    chk(name, 32'(instruction_valid), 32'd1);
  endtask

  initial begin
    //            stall ready rv  addr          iv  pc
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10C};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10C};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10C};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10C};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10C};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h118, 1'b1, 32'h110};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h114};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h120, 1'b1, 32'h118};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h120, 1'b1, 32'h11C};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h120, 1'b0, 32'h0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 32'h120, 1'b0, 32'h0};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 32'h120, 1'b0, 32'h0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 32'h124, 1'b0, 32'h0};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 32'h128, 1'b1, 32'h120};

    // streaming, 5-cycle stall, 4 cycles of imem backpressure (1-cycle memory)
    lat = 1;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      if (k > 0) step();
      stall = tbl[k].stall;
      imem_req_ready = tbl[k].ready;
      @(negedge clock);
      chk($sformatf("tbl%0d_req_valid", k), 32'(imem_req_valid), 32'(tbl[k].exp_rv));
      if (tbl[k].exp_rv) chk($sformatf("tbl%0d_req_addr", k), imem_req_addr, tbl[k].exp_addr);
      chk($sformatf("tbl%0d_ivalid", k), 32'(instruction_valid), 32'(tbl[k].exp_iv));
      chk($sformatf("tbl%0d_ipc", k), instruction_pc, tbl[k].exp_pc);
      chk($sformatf("tbl%0d_instr", k), instruction, tbl[k].exp_iv ? (tbl[k].exp_pc ^ KEY) : NOP);
    end
    stall = 1'b0; imem_req_ready = 1'b1;

    // redirect with two requests in flight (3-cycle memory), after a mid-run reset
    lat = 3;
    do_reset();
    step(); step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clock);
    chk("redir_full_credit", 32'(imem_req_valid), 32'd0);
    step(); redirect_valid = 1'b0;
    @(negedge clock);
    chk("drain1_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drain1_ivalid", 32'(instruction_valid), 32'd0);
    step(); @(negedge clock);
    chk("drain2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drain2_ivalid", 32'(instruction_valid), 32'd0);
    step(); @(negedge clock);
    chk("post_drain_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_drain_addr", imem_req_addr, 32'h200);
    wait_iv("redir_first_valid");
    chk("redir_first_pc", instruction_pc, 32'h200);
    chk("redir_first_instr", instruction, 32'h200 ^ KEY);

    // redirect coinciding with a live response and a stall; misaligned target
    #1;
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h303;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    @(negedge clock);
    chk("collide_ivalid", 32'(instruction_valid), 32'd0);
    chk("collide_instr", instruction, NOP);
    chk("collide_ipc", instruction_pc, 32'd0);
    chk("collide_req_valid", 32'(imem_req_valid), 32'd1);
    chk("collide_req_addr", imem_req_addr, 32'h300);
    wait_iv("align_first_valid");
    chk("align_first_pc", instruction_pc, 32'h300);
    chk("align_first_instr", instruction, 32'h300 ^ KEY);

    // pc wrap from the top of the address space, redirect taken in BOOT
    lat = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0;
    @(negedge clock);
    chk("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_req_valid0", 32'(imem_req_valid), 32'd1);
    step(); @(negedge clock);
    chk("wrap_req_addr1", imem_req_addr, 32'h0);
    wait_iv("wrap_valid");
    chk("wrap_pc0", instruction_pc, 32'hFFFF_FFFC);
    step(); @(negedge clock);
    chk("wrap_ivalid1", 32'(instruction_valid), 32'd1);
    chk("wrap_pc1", instruction_pc, 32'h0);
    chk("wrap_instr1", instruction, 32'h0 ^ KEY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
